// File: rtl/dma_pkg.sv
// -----------------------------------------------------------------------------
// dma_pkg
//   Shared definitions for the CPU-side DMA host slice.
//   - State encoding for the host FSM (IDLE / ISSUE / XFER / WAIT_INT).
//   - WORD_SIZE: global data word width.
//   - DMA_CHUNKS / CHUNK_WORDS: shape of a typical cycle-stealing transfer,
//     shared with the bench so both sides agree on burst geometry.
// -----------------------------------------------------------------------------
package dma_pkg;

    localparam int unsigned WORD_SIZE = 16;

    typedef logic [1:0] state_t;

    localparam state_t IDLE     = 2'd0;
    localparam state_t ISSUE    = 2'd1;
    localparam state_t XFER     = 2'd2;
    localparam state_t WAIT_INT = 2'd3;

    localparam int unsigned DMA_CHUNKS  = 3;
    localparam int unsigned CHUNK_WORDS = 4;

    // States in which the DMA engine is actively working on a transfer and
    // its completion interrupt is meaningful.
    function automatic logic in_transfer(input state_t s);
        return (s == XFER) || (s == WAIT_INT);
    endfunction

endpackage

// File: rtl/dma_bus_arbiter.sv
// -----------------------------------------------------------------------------
// dma_bus_arbiter
//   Memory-bus grant register between the CPU and the DMA engine.
//   A fresh grant is only given when the CPU is not using the bus this cycle;
//   once granted, the DMA keeps the bus for as long as it holds BR.
//
// Ports:
//   CLK          system clock
//   reset_n      asynchronous active-low reset (drops BG immediately)
//   enable       a transfer is outstanding; no grant is ever given otherwise
//   clear        force the grant low on the next edge (completion / abort)
//   BR           bus request from the DMA engine (level)
//   cpu_mem_req  CPU wants the memory bus this cycle
//   BG           registered bus grant to the DMA engine
//   cpu_stall    combinational: CPU request collides with an active grant
// -----------------------------------------------------------------------------
module dma_bus_arbiter (
    input  logic CLK,
    input  logic reset_n,
    input  logic enable,
    input  logic clear,
    input  logic BR,
    input  logic cpu_mem_req,
    output logic BG,
    output logic cpu_stall
);

    logic bg_q;
    logic bg_d;

    always_comb begin
        bg_d = 1'b0;
        if (enable && !clear) begin
            if (bg_q) begin
                // Holding grant ignores the CPU; it only ends with BR.
                bg_d = BR;
            end else begin
                // New grant waits until the CPU has finished its access.
                bg_d = BR && !cpu_mem_req;
            end
        end
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            bg_q <= 1'b0;
        end else begin
            bg_q <= bg_d;
        end
    end

    assign BG        = bg_q;
    assign cpu_stall = cpu_mem_req & bg_q;

endmodule

// File: rtl/dma_bus_host.sv
// -----------------------------------------------------------------------------
// dma_bus_host
//   CPU-side counterpart of the DMA engine. Turns a device data-ready pulse
//   into a single-cycle DMA start command, arbitrates the memory bus against
//   the CPU, and converts the DMA end-of-transfer interrupt into a done pulse.
//   One further request arriving while a transfer is outstanding is queued.
//
// Build option:
//   DMA_TIMEOUT_EN  when defined, a transfer that has not seen dma_int within
//                   TIMEOUT cycles of its command is aborted and err is set
//                   (sticky until reset). When undefined, err is tied low and
//                   the wait for dma_int is unbounded.
//
// Parameters:
//   WORD_SIZE  data word width (global word size)
//   TIMEOUT    cycles allowed from cmd to dma_int (DMA_TIMEOUT_EN only)
//
// Ports:
//   CLK          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   dev_req      device data-ready request, one-cycle pulse
//   BR           DMA bus request, level
//   dma_int      DMA end-of-transfer interrupt, one-cycle pulse
//   cpu_mem_req  CPU wants the memory bus this cycle
//   cmd          DMA start command, registered one-cycle pulse
//   BG           bus grant to the DMA, registered level
//   cpu_stall    combinational cpu_mem_req & BG
//   busy         a transfer is outstanding (from cmd until done)
//   done         one-cycle completion pulse to the CPU
//   err          sticky timeout flag
// -----------------------------------------------------------------------------
module dma_bus_host
    import dma_pkg::*;
#(
    parameter int unsigned WORD_SIZE = dma_pkg::WORD_SIZE,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic CLK,
    input  logic reset_n,
    input  logic dev_req,
    input  logic BR,
    input  logic dma_int,
    input  logic cpu_mem_req,
    output logic cmd,
    output logic BG,
    output logic cpu_stall,
    output logic busy,
    output logic done,
    output logic err
);

    // Elaboration-time sanity check on the configuration.
    if (WORD_SIZE == 0 || TIMEOUT < 2) begin : g_param_check
        $error("dma_bus_host: WORD_SIZE must be nonzero and TIMEOUT at least 2");
    end

    state_t state_q, state_d;
    logic   pending_q, pending_d;
    logic   seen_q, seen_d;      // at least one grant given in this transfer
    logic   cmd_q, cmd_d;
    logic   busy_q, busy_d;
    logic   done_q, done_d;
    logic   err_q, err_d;
    logic   in_xfer;
    logic   timeout_hit;
    logic   bus_clear;

    assign in_xfer = in_transfer(state_q);

`ifdef DMA_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT);

    // Counts cycles since the ISSUE cycle (0 in ISSUE), so the abort becomes
    // visible exactly TIMEOUT cycles after cmd.
    logic [CntW-1:0] tcnt_q, tcnt_d;

    // A completion arriving in the last allowed cycle still wins.
    assign timeout_hit = in_xfer && !dma_int && (tcnt_q == CntW'(TIMEOUT - 1));

    always_comb begin
        tcnt_d = tcnt_q;
        if (state_q == IDLE) begin
            if (state_d == ISSUE) begin
                tcnt_d = '0;
            end
        end else begin
            tcnt_d = tcnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            tcnt_q <= '0;
        end else begin
            tcnt_q <= tcnt_d;
        end
    end

    assign err_d = err_q | timeout_hit;
`else
    assign timeout_hit = 1'b0;
    assign err_d       = 1'b0;
`endif

    // Completion or abort drops the grant even if BR is still high.
    assign bus_clear = in_xfer && (dma_int || timeout_hit);

    dma_bus_arbiter u_arbiter (
        .CLK         (CLK),
        .reset_n     (reset_n),
        .enable      (busy_q),
        .clear       (bus_clear),
        .BR          (BR),
        .cpu_mem_req (cpu_mem_req),
        .BG          (BG),
        .cpu_stall   (cpu_stall)
    );

    // State register.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                // The done cycle is a settling cycle: a queued or new request
                // starts on the following IDLE cycle at the earliest.
                if ((dev_req || pending_q) && !done_q) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = XFER;
            end
            XFER: begin
                if (dma_int || timeout_hit) begin
                    state_d = IDLE;
                end else if (!BR && !BG && seen_q) begin
                    state_d = WAIT_INT;
                end
            end
            WAIT_INT: begin
                if (dma_int || timeout_hit) begin
                    state_d = IDLE;
                end else if (BR) begin
                    state_d = XFER;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output and side-state next values (registered below).
    always_comb begin
        cmd_d     = (state_d == ISSUE);
        busy_d    = (state_d != IDLE);
        done_d    = in_xfer && dma_int;
        seen_d    = (state_d == ISSUE) ? 1'b0 : (seen_q | BG);
        // Single-deep, saturating request queue; it is consumed on the way
        // into ISSUE. Outside that, any request is remembered, which also
        // covers a request landing in the done cycle.
        pending_d = (state_d == ISSUE) ? 1'b0 : (pending_q | dev_req);
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            cmd_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            seen_q    <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            cmd_q     <= cmd_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            seen_q    <= seen_d;
            pending_q <= pending_d;
        end
    end

    assign cmd  = cmd_q;
    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_dma_bus_host.sv
// -----------------------------------------------------------------------------
// tb_dma_bus_host
//   Self-checking bench for dma_bus_host: a cycle-level behavioural model of
//   the host's observable rules, a compare process on every falling edge,
//   directed scenarios with literal expectations, then randomized traffic.
// -----------------------------------------------------------------------------
module tb_dma_bus_host;
    import dma_pkg::*;

    localparam int unsigned TIMEOUT = 64;
`ifdef DMA_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic CLK;
    logic reset_n;
    logic dev_req;
    logic BR;
    logic dma_int;
    logic cpu_mem_req;
    logic cmd;
    logic BG;
    logic cpu_stall;
    logic busy;
    logic done;
    logic err;

    int checks   = 0;
    int failures = 0;

    dma_bus_host #(
        .WORD_SIZE (16),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .CLK         (CLK),
        .reset_n     (reset_n),
        .dev_req     (dev_req),
        .BR          (BR),
        .dma_int     (dma_int),
        .cpu_mem_req (cpu_mem_req),
        .cmd         (cmd),
        .BG          (BG),
        .cpu_stall   (cpu_stall),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------------
    // Behavioural model: expected values of the registered outputs.
    // ---------------------------------------------------------------------
    logic m_cmd, m_bg, m_busy, m_done, m_err, m_pend, m_ever, m_gap;
    int   m_since;
    logic running, fin, tmo, start;

    always @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            m_cmd = 0; m_bg = 0; m_busy = 0; m_done = 0; m_err = 0;
            m_pend = 0; m_ever = 0; m_gap = 0; m_since = 0;
        end else begin
            // Transfer is running once the command cycle is over.
            running = m_busy && !m_cmd;
            fin     = running && dma_int;
            tmo     = TO_EN && running && !dma_int && (m_since == int'(TIMEOUT) - 1);
            // No start in the cycle a done pulse is shown.
            start   = !m_busy && (dev_req || m_pend) && !m_done;

            m_gap   = running && !fin && !tmo &&
                      (m_gap ? !BR : (!BR && !m_bg && m_ever));
            m_ever  = start ? 1'b0 : (m_ever || m_bg);
            m_bg    = m_busy && !fin && !tmo && (m_bg ? BR : (BR && !cpu_mem_req));
            m_pend  = start ? 1'b0 : (m_pend || dev_req);
            m_since = start ? 0 : m_since + 1;
            m_busy  = start || (m_busy && !fin && !tmo);
            m_err   = m_err || tmo;
            m_cmd   = start;
            m_done  = fin;
        end
    end

    // Compare process: every falling edge outside reset.
    always @(negedge CLK) begin
        if (reset_n) begin
            chk("cmd", cmd, m_cmd);
            chk("bg", BG, m_bg);
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("err", err, m_err);
            chk("cpu_stall", cpu_stall, cpu_mem_req & m_bg);
            chk("wait_int_state", dut.state_q == WAIT_INT, m_gap);
        end
    end

    // ---------------------------------------------------------------------
    // Stimulus helpers
    // ---------------------------------------------------------------------
    task automatic drive(input logic d, input logic b, input logic i, input logic c);
        dev_req = d; BR = b; dma_int = i; cpu_mem_req = c;
    endtask

    task automatic do_reset();
        @(posedge CLK); #1;
        reset_n = 1'b0;
        drive(0, 0, 0, 0);
        repeat (2) @(posedge CLK);
        #1 reset_n = 1'b1;
    endtask

    // Start of cycle k: inputs change just after the rising edge.
    task automatic cyc();
        @(posedge CLK); #1;
    endtask

    int bg_cnt, done_cnt, cmd_cnt;

    initial begin
        reset_n = 1'b0;
        drive(0, 0, 0, 0);
        do_reset();

        // Basic transfer, plus BR / dma_int while idle being ignored.
        for (int k = 0; k < 35; k++) begin
            cyc();
            drive(k == 5, (k >= 1 && k <= 3) || (k >= 9 && k < 22), (k == 2) || (k == 30), 0);
            @(negedge CLK);
            if (k == 3)  begin chk("idle_dma_int_done", done, 0); chk("idle_busy", busy, 0); end
            if (k == 4)  chk("idle_br_no_grant", BG, 0);
            if (k == 6)  begin chk("basic_cmd", cmd, 1); chk("basic_busy", busy, 1); end
            if (k == 7)  chk("basic_cmd_one_cycle", cmd, 0);
            if (k == 9)  chk("basic_bg_before", BG, 0);
            if (k == 10) chk("basic_bg_rise", BG, 1);
            if (k == 22) chk("basic_bg_hold", BG, 1);
            if (k == 23) chk("basic_bg_fall", BG, 0);
            if (k == 24) chk("basic_wait_int", dut.state_q == WAIT_INT, 1);
            if (k == 31) begin chk("basic_done", done, 1); chk("basic_busy_clear", busy, 0); end
            if (k == 32) chk("basic_done_one_cycle", done, 0);
        end

        // Grant deferral while the CPU owns the bus; stall during grant.
        do_reset();
        for (int k = 0; k < 30; k++) begin
            cyc();
            drive(k == 5, k >= 10 && k <= 20, k == 24, (k >= 10 && k <= 13) || k == 17);
            @(negedge CLK);
            if (k == 13) chk("defer_bg_wait", BG, 0);
            if (k == 14) chk("defer_bg_still_low", BG, 0);
            if (k == 15) chk("defer_bg_rise", BG, 1);
            if (k == 17) begin chk("defer_stall", cpu_stall, 1); chk("defer_bg_kept", BG, 1); end
            if (k == 18) chk("defer_no_stall", cpu_stall, 0);
            if (k == 22) chk("defer_bg_fall", BG, 0);
            if (k == 25) chk("defer_done", done, 1);
        end

        // Cycle stealing: DMA_CHUNKS bursts of CHUNK_WORDS, 2 idle cycles apart.
        do_reset();
        bg_cnt = 0; done_cnt = 0;
        for (int k = 0; k < 36; k++) begin
            cyc();
            drive(k == 5,
                  k >= 10 && ((k - 10) % 6) < int'(CHUNK_WORDS) && ((k - 10) / 6) < int'(DMA_CHUNKS),
                  k == 30, 0);
            @(negedge CLK);
            if (BG) bg_cnt++;
            if (done) done_cnt++;
            if (k == 10) chk("steal_bg_late", BG, 0);
            if (k == 11) chk("steal_bg_rise", BG, 1);
            if (k == 16 || k == 22 || k == 28) chk("steal_wait", dut.state_q == WAIT_INT, 1);
            if (k == 17 || k == 23) chk("steal_xfer", dut.state_q == XFER, 1);
            if (k == 17 || k == 23) chk("steal_regrant", BG, 1);
        end
        chk("steal_bg_cycles", bg_cnt == int'(DMA_CHUNKS * CHUNK_WORDS), 1);
        chk("steal_single_done", done_cnt == 1, 1);

        // Queueing: second request queued, third dropped.
        do_reset();
        cmd_cnt = 0;
        for (int k = 0; k < 46; k++) begin
            cyc();
            drive(k == 5 || k == 12 || k == 14,
                  (k >= 9 && k <= 15) || (k >= 26 && k <= 28), k == 20 || k == 32, 0);
            @(negedge CLK);
            if (cmd) cmd_cnt++;
            if (k == 21) chk("queue_done", done, 1);
            if (k == 22) chk("queue_no_early_cmd", cmd, 0);
            if (k == 23) chk("queue_second_cmd", cmd, 1);
            if (k == 33) chk("queue_second_done", done, 1);
        end
        chk("queue_cmd_count", cmd_cnt == 2, 1);

        // Reset while the grant is held.
        do_reset();
        for (int k = 0; k < 13; k++) begin
            cyc();
            drive(k == 5, k >= 9, 0, 0);
            @(negedge CLK);
            if (k == 12) begin chk("rst_pre_bg", BG, 1); chk("rst_pre_busy", busy, 1); end
        end
        #1 reset_n = 1'b0;
        #1;
        chk("rst_bg_clear", BG, 0);
        chk("rst_busy_clear", busy, 0);
        chk("rst_cmd_clear", cmd, 0);
        chk("rst_done_clear", done, 0);
        chk("rst_err_clear", err, 0);
        cyc();
        drive(0, 0, 0, 0);
        cyc();
        reset_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cyc();
            drive(k == 2, 0, 0, 0);
            @(negedge CLK);
            if (k == 3) begin chk("rst_restart_cmd", cmd, 1); chk("rst_restart_busy", busy, 1); end
        end

`ifdef DMA_TIMEOUT_EN
        // Timeout: no BR and no dma_int until well after the limit.
        do_reset();
        done_cnt = 0;
        for (int k = 0; k < 90; k++) begin
            cyc();
            drive(k == 5, 0, k == 80, 0);
            @(negedge CLK);
            if (done) done_cnt++;
            if (k == 6)  chk("to_cmd", cmd, 1);
            if (k == 69) begin chk("to_busy_before", busy, 1); chk("to_err_before", err, 0); end
            if (k == 70) begin chk("to_busy_clear", busy, 0); chk("to_err_set", err, 1); end
            if (k == 81) begin chk("to_late_int_ignored", done, 0); chk("to_err_sticky", err, 1); end
        end
        chk("to_no_done", done_cnt == 0, 1);
`endif

        // Randomized traffic against the model.
        do_reset();
        begin
            logic br_r;
            br_r = 1'b0;
            for (int k = 0; k < 3000; k++) begin
                cyc();
                if ($urandom_range(0, 3) == 0) br_r = ~br_r;
                drive($urandom_range(0, 9) == 0, br_r, $urandom_range(0, 24) == 0,
                      $urandom_range(0, 2) == 0);
            end
        end
        cyc();
        drive(0, 0, 0, 0);
        @(negedge CLK);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
